// File: rtl/i2c_pkg.sv
// Shared I2C definitions: byte-master command codes and the transaction sequencer's state encoding.
package i2c_pkg;

    localparam logic [2:0] CMD_START = 3'b000;
    localparam logic [2:0] CMD_WR    = 3'b001;
    localparam logic [2:0] CMD_RD    = 3'b010;
    localparam logic [2:0] CMD_STOP  = 3'b011;
    localparam logic [2:0] CMD_RESET = 3'b100;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR_W,
        S_REG,
        S_DATA_W,
        S_RESTART,
        S_ADDR_R,
        S_DATA_R,
        S_STOP
    } seq_state_t;

    typedef enum logic [1:0] {
        I_IDLE,
        I_WAIT_RDY,
        I_PULSE,
        I_WAIT_FIN
    } iss_state_t;

endpackage

// File: rtl/i2c_cmd_issuer.sv
// Runs one master step: wait for ready, pulse wr_i2c, skip the stale ready cycle, wait for the step to finish.
import i2c_pkg::*;

module i2c_cmd_issuer (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [2:0] cmd,
    input  logic [7:0] din,
    output logic       busy,
    output logic       issue,
    output logic       step_done,
    output logic       ack,
    output logic [7:0] dout,
    output logic [2:0] i2c_cmd,
    output logic [7:0] i2c_din,
    output logic       i2c_wr,
    input  logic       i2c_ready,
    input  logic       i2c_done_tick,
    input  logic       i2c_ack,
    input  logic [7:0] i2c_dout
);

    iss_state_t state;

    assign busy  = (state != I_IDLE);
    assign issue = (state == I_WAIT_RDY) && i2c_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= I_IDLE;
            step_done <= 1'b0;
            ack       <= 1'b0;
            dout      <= 8'h00;
            i2c_cmd   <= 3'b000;
            i2c_din   <= 8'h00;
            i2c_wr    <= 1'b0;
        end else begin
            step_done <= 1'b0;
            i2c_wr    <= 1'b0;
            if (i2c_done_tick && state != I_IDLE) begin
                ack  <= i2c_ack;
                dout <= i2c_dout;
            end
            case (state)
                I_IDLE: if (go) begin
                    i2c_cmd <= cmd;
                    i2c_din <= din;
                    state   <= I_WAIT_RDY;
                end
                I_WAIT_RDY: if (i2c_ready) begin
                    i2c_wr <= 1'b1;
                    state  <= I_PULSE;
                end
                // master's ready has not dropped yet during the wr pulse
                I_PULSE: state <= I_WAIT_FIN;
                I_WAIT_FIN: if (i2c_ready) begin
                    step_done <= 1'b1;
                    state     <= I_IDLE;
                end
                default: state <= I_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Register-level I2C transaction sequencer: expands (slave, reg, len) requests into master START/WR/RD/STOP steps.
import i2c_pkg::*;

module i2c_txn_sequencer #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic [6:0]       req_addr,
    input  logic [7:0]       req_reg,
    input  logic [LEN_W-1:0] req_len,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic             err_nack,
    output logic [2:0]       i2c_cmd,
    output logic [7:0]       i2c_din,
    output logic             i2c_wr,
    input  logic             i2c_ready,
    input  logic             i2c_done_tick,
    input  logic             i2c_ack,
    input  logic [7:0]       i2c_dout
);

    seq_state_t       state;
    logic             launched, go;
    logic [LEN_W-1:0] cnt, len_q;
    logic [6:0]       addr_q;
    logic [7:0]       reg_q;
    logic             rw_q;
    logic [2:0]       step_cmd;
    logic [7:0]       step_din;
    logic             can_go, last;
    logic             busy, issue, step_done, iss_ack;
    logic [7:0]       iss_dout;

    i2c_cmd_issuer u_issuer (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .cmd           (step_cmd),
        .din           (step_din),
        .busy          (busy),
        .issue         (issue),
        .step_done     (step_done),
        .ack           (iss_ack),
        .dout          (iss_dout),
        .i2c_cmd       (i2c_cmd),
        .i2c_din       (i2c_din),
        .i2c_wr        (i2c_wr),
        .i2c_ready     (i2c_ready),
        .i2c_done_tick (i2c_done_tick),
        .i2c_ack       (i2c_ack),
        .i2c_dout      (i2c_dout)
    );

    assign last   = (cnt == LEN_W'(1));
    assign can_go = (state != S_IDLE) && !launched && !busy && (state != S_DATA_W || wr_valid);

    always_comb begin
        step_cmd = CMD_START;
        step_din = 8'h00;
        case (state)
            S_ADDR_W: begin step_cmd = CMD_WR; step_din = {addr_q, 1'b0}; end
            S_REG:    begin step_cmd = CMD_WR; step_din = reg_q;           end
            S_DATA_W: begin step_cmd = CMD_WR; step_din = wr_data;         end
            S_ADDR_R: begin step_cmd = CMD_WR; step_din = {addr_q, 1'b1};  end
            // master NACKs only the final read byte
            S_DATA_R: begin step_cmd = CMD_RD; step_din = {7'b0, last};    end
            S_STOP:   step_cmd = CMD_STOP;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            launched  <= 1'b0;
            go        <= 1'b0;
            cnt       <= '0;
            len_q     <= '0;
            addr_q    <= 7'h00;
            reg_q     <= 8'h00;
            rw_q      <= 1'b0;
            req_ready <= 1'b0;
            wr_ready  <= 1'b0;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            err_nack  <= 1'b0;
        end else begin
            go       <= 1'b0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            wr_ready <= issue && (state == S_DATA_W);
            if (can_go) begin
                go       <= 1'b1;
                launched <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (!req_ready)
                        req_ready <= 1'b1;
                    else if (req_valid) begin
                        addr_q    <= req_addr;
                        reg_q     <= req_reg;
                        len_q     <= req_len;
                        rw_q      <= req_rw;
                        err_nack  <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= S_START;
                    end
                end
                default: if (step_done) begin
                    launched <= 1'b0;
                    case (state)
                        S_START:   state <= S_ADDR_W;
                        S_RESTART: state <= S_ADDR_R;
                        S_ADDR_W: begin
                            if (iss_ack) begin err_nack <= 1'b1; state <= S_STOP; end
                            else state <= S_REG;
                        end
                        S_REG: begin
                            if (iss_ack) begin err_nack <= 1'b1; state <= S_STOP; end
                            else if (len_q == '0) state <= S_STOP;
                            else begin
                                cnt   <= len_q;
                                state <= rw_q ? S_RESTART : S_DATA_W;
                            end
                        end
                        S_DATA_W: begin
                            if (iss_ack) begin err_nack <= 1'b1; state <= S_STOP; end
                            else if (last) state <= S_STOP;
                            else cnt <= cnt - LEN_W'(1);
                        end
                        S_ADDR_R: begin
                            if (iss_ack) begin err_nack <= 1'b1; state <= S_STOP; end
                            else state <= S_DATA_R;
                        end
                        S_DATA_R: begin
                            rd_data  <= iss_dout;
                            rd_valid <= 1'b1;
                            if (last) state <= S_STOP;
                            else cnt <= cnt - LEN_W'(1);
                        end
                        S_STOP: begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench: behavioural byte-master/slave responder plus a transaction-level model of the expected command stream.
import i2c_pkg::*;

module tb_i2c_txn_sequencer;

    localparam int LEN_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic             req_valid = 0, req_ready, req_rw = 0;
    logic [6:0]       req_addr = 0;
    logic [7:0]       req_reg = 0;
    logic [LEN_W-1:0] req_len = 0;
    logic [7:0]       wr_data = 0;
    logic             wr_valid = 0, wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid, done, err_nack;
    logic [2:0]       i2c_cmd;
    logic [7:0]       i2c_din;
    logic             i2c_wr;
    logic             i2c_ready, i2c_done_tick, i2c_ack;
    logic [7:0]       i2c_dout;

    i2c_txn_sequencer #(.LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_reg(req_reg), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err_nack(err_nack),
        .i2c_cmd(i2c_cmd), .i2c_din(i2c_din), .i2c_wr(i2c_wr),
        .i2c_ready(i2c_ready), .i2c_done_tick(i2c_done_tick),
        .i2c_ack(i2c_ack), .i2c_dout(i2c_dout)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;

    logic [10:0] obs_q[$];
    logic [7:0]  mem [256];
    logic [7:0]  mem_ref [256];
    logic [7:0]  tx_data [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte master + single slave at 0x50; slave NACKs data byte 0xEE and any other address.
    initial begin : master_model
        bit         m_busy, addr_phase, sel;
        int         m_cnt, wcnt;
        logic [2:0] m_cmd;
        logic [7:0] m_din, ptr;
        m_busy = 0; addr_phase = 0; sel = 0; m_cnt = 0; wcnt = 0; ptr = 0;
        m_cmd = 0; m_din = 0;
        i2c_ready = 1; i2c_done_tick = 0; i2c_ack = 0; i2c_dout = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                i2c_ready = 1; i2c_done_tick = 0; m_busy = 0; addr_phase = 0; sel = 0;
            end else if (i2c_done_tick) begin
                i2c_done_tick = 0; i2c_ready = 1; m_busy = 0;
            end else if (m_busy) begin
                if (m_cnt > 0) m_cnt--;
                else if (m_cmd == CMD_WR) begin
                    if (addr_phase) begin
                        addr_phase = 0; sel = (m_din[7:1] == 7'h50); wcnt = 0; i2c_ack = !sel;
                    end else if (!sel) i2c_ack = 1;
                    else if (wcnt == 0) begin ptr = m_din; wcnt = 1; i2c_ack = 0; end
                    else if (m_din == 8'hEE) i2c_ack = 1;
                    else begin mem[ptr] = m_din; ptr++; i2c_ack = 0; end
                    i2c_done_tick = 1;
                end else if (m_cmd == CMD_RD) begin
                    i2c_dout = mem[ptr]; ptr++; i2c_ack = 0; i2c_done_tick = 1;
                end else begin
                    i2c_ready = 1; m_busy = 0;
                end
            end else if (i2c_wr) begin
                obs_q.push_back({i2c_cmd, i2c_din});
                m_cmd = i2c_cmd; m_din = i2c_din;
                if (i2c_cmd == CMD_START) addr_phase = 1;
                i2c_ready = 0; m_busy = 1; m_cnt = $urandom_range(1, 4);
            end
        end
    end

    task automatic run_txn(input string tag, input bit rw, input logic [6:0] addr,
                           input logic [7:0] regb, input int len, input int stall_at, input int rst_at);
        logic [10:0] exp_q[$];
        logic [7:0]  exp_rd[$], rd_got[$];
        logic [7:0]  p;
        bit          exp_nack, dn, aborted, nack_seen, rdy_at_done, stalling;
        int          exp_wr, wrr, wi, cyc, stall_cnt, obs_mark;
        exp_nack = 0; exp_wr = 0; wrr = 0; stall_cnt = 0; obs_mark = 0;
        nack_seen = 0; rdy_at_done = 0;
        // expected command stream straight from the transaction rules
        exp_q.push_back({CMD_START, 8'h00});
        exp_q.push_back({CMD_WR, addr, 1'b0});
        if (addr != 7'h50) exp_nack = 1;
        else begin
            exp_q.push_back({CMD_WR, regb});
            if (!rw) begin
                for (int i = 0; i < len; i++) begin
                    exp_q.push_back({CMD_WR, tx_data[i]});
                    exp_wr++;
                    if (tx_data[i] == 8'hEE) begin exp_nack = 1; break; end
                    p = regb + 8'(i);
                    mem_ref[p] = tx_data[i];
                end
            end else if (len > 0) begin
                exp_q.push_back({CMD_START, 8'h00});
                exp_q.push_back({CMD_WR, addr, 1'b1});
                for (int i = 0; i < len; i++) begin
                    exp_q.push_back({CMD_RD, 7'b0, (i == len - 1)});
                    p = regb + 8'(i);
                    exp_rd.push_back(mem_ref[p]);
                end
            end
        end
        exp_q.push_back({CMD_STOP, 8'h00});

        obs_q.delete();
        cyc = 0;
        while (!req_ready && cyc < 200) begin @(negedge clk); cyc++; end
        check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1; req_rw = rw; req_addr = addr; req_reg = regb; req_len = LEN_W'(len);
        wi = 0; wr_data = tx_data[0]; wr_valid = !rw && len > 0 && stall_at != 0;
        cyc = 0; dn = 0; aborted = 0;
        while (!dn && !aborted && cyc < 3000) begin
            @(negedge clk); cyc++;
            req_valid = 0;
            if (wr_ready) begin wrr++; wi++; end
            if (rd_valid) rd_got.push_back(rd_data);
            if (done) begin dn = 1; nack_seen = err_nack; rdy_at_done = req_ready; end
            if (rst_at >= 0 && wrr == rst_at) begin
                reset = 0;
                @(negedge clk);
                check({tag, "/rst_outs"}, 32'({req_ready, wr_ready, rd_data, rd_valid, done,
                      err_nack, i2c_cmd, i2c_din, i2c_wr}), 32'd0);
                wr_valid = 0;
                repeat (3) @(negedge clk);
                reset = 1;
                @(negedge clk);
                check({tag, "/rst_release_ready"}, 32'(req_ready), 32'd1);
                aborted = 1;
            end else begin
                stalling = (wi == stall_at) && (stall_cnt < 50);
                if (stalling) begin
                    if (stall_cnt == 0) obs_mark = obs_q.size();
                    stall_cnt++;
                    if (stall_cnt == 50) check({tag, "/stall_no_cmd"}, 32'(obs_q.size()), 32'(obs_mark));
                end
                wr_valid = !rw && wi < len && !stalling;
                if (wi < 16) wr_data = tx_data[wi];
            end
        end
        wr_valid = 0;
        if (aborted) begin
            foreach (mem[i]) mem_ref[i] = mem[i];
            return;
        end
        check({tag, "/done_seen"}, 32'(dn), 32'd1);
        if (dn) begin
            check({tag, "/err_nack"}, 32'(nack_seen), 32'(exp_nack));
            check({tag, "/req_ready_at_done"}, 32'(rdy_at_done), 32'd0);
            check({tag, "/cmd_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
            foreach (exp_q[i])
                if (i < obs_q.size()) check({tag, "/cmd"}, 32'(obs_q[i]), 32'(exp_q[i]));
            check({tag, "/wr_ready_count"}, 32'(wrr), 32'(exp_wr));
            check({tag, "/rd_count"}, 32'(rd_got.size()), 32'(exp_rd.size()));
            foreach (exp_rd[i])
                if (i < rd_got.size()) check({tag, "/rd_data"}, 32'(rd_got[i]), 32'(exp_rd[i]));
            @(negedge clk);
            check({tag, "/done_pulse"}, 32'(done), 32'd0);
            check({tag, "/err_nack_held"}, 32'(err_nack), 32'(exp_nack));
        end
    endtask

    initial begin : main
        int len;
        bit rw;
        logic [6:0] addr;
        logic [7:0] regb;
        foreach (mem[i]) begin mem[i] = 8'($urandom); mem_ref[i] = mem[i]; end
        mem[8'h20] = 8'h11; mem[8'h21] = 8'h22; mem[8'h22] = 8'h33;
        mem_ref[8'h20] = 8'h11; mem_ref[8'h21] = 8'h22; mem_ref[8'h22] = 8'h33;
        foreach (tx_data[i]) tx_data[i] = 8'h00;

        repeat (4) @(negedge clk);
        check("reset_outs", 32'({req_ready, wr_ready, rd_data, rd_valid, done, err_nack,
              i2c_cmd, i2c_din, i2c_wr}), 32'd0);
        reset = 1;
        @(negedge clk);
        check("ready_after_release", 32'(req_ready), 32'd1);

        tx_data[0] = 8'hA5; tx_data[1] = 8'h3C;
        run_txn("wr_basic", 0, 7'h50, 8'h10, 2, -1, -1);
        run_txn("rd_basic", 1, 7'h50, 8'h20, 3, -1, -1);
        run_txn("wr_absent", 0, 7'h3F, 8'h10, 2, -1, -1);
        tx_data[0] = 8'h01; tx_data[1] = 8'h02; tx_data[2] = 8'h03;
        run_txn("wr_stall", 0, 7'h50, 8'h40, 3, 1, -1);
        run_txn("rd_len0", 1, 7'h50, 8'h05, 0, -1, -1);
        tx_data[0] = 8'hA5; tx_data[1] = 8'h3C;
        run_txn("wr_reset", 0, 7'h50, 8'h10, 2, -1, 2);
        run_txn("wr_after_reset", 0, 7'h50, 8'h10, 2, -1, -1);
        tx_data[0] = 8'h77; tx_data[1] = 8'hEE; tx_data[2] = 8'h99;
        run_txn("wr_data_nack", 0, 7'h50, 8'h60, 3, -1, -1);

        for (int t = 0; t < 20; t++) begin
            rw   = 1'($urandom);
            addr = ($urandom_range(0, 4) == 0) ? 7'h3F : 7'h50;
            regb = 8'($urandom);
            len  = $urandom_range(0, 15);
            foreach (tx_data[i]) tx_data[i] = ($urandom_range(0, 9) == 0) ? 8'hEE : 8'($urandom);
            run_txn("rand", rw, addr, regb, len, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
